uart_tx: RTL and testbench

- Serial transmitter paired with the team's UART receiver. Frame format: 8N1 by default; optional parity and 2 stop bits.
- Accepts bytes over a valid/ready handshake into a one-entry holding register, so the next byte can be queued while the current frame shifts out.
- Sits between fabric logic and the board TX pin. Back-to-back frames leave no idle gap.

---
 rtl/uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with a one-entry holding register.
// It sends 8 data bits LSB first and supports optional parity and one or two
// stop bits. Every output is registered. The line lags the FSM state by one
// cycle, so a byte accepted at edge N drives the start bit from edge N+2.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tx_byte    byte to send; sampled when tx_valid && tx_ready
//   tx_valid   tx_byte is valid
//   tx_ready   holding register empty; a byte can be accepted
//   serial_out UART line; idles high
//   tx_busy    high while a frame is on the line
//   tx_done    one-cycle pulse on the last cycle of the final stop bit
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned      CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             tx_ready_q, tx_ready_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic bit_end;
  logic load;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    serial_d    = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;

    bit_end = (cnt_q == CNT_MAX);
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        busy_d   = 1'b1;
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        serial_d = shift_q[0];
        busy_d   = 1'b1;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        serial_d = parity_q;
        busy_d   = 1'b1;
        if (bit_end) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        busy_d = 1'b1;
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            done_d = 1'b1;
            bit_d  = '0;
            // A queued byte starts the next frame with no idle gap.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Drain the holding register into the shifter.
    if (load) begin
      shift_d     = hold_q;
      parity_d    = (^hold_q) ^ PARITY_ODD;
      hold_full_d = 1'b0;
    end

    // Acceptance only happens while the hold register is empty, so it cannot
    // coincide with a drain.
    if (tx_valid && tx_ready_q) begin
      hold_d      = tx_byte;
      hold_full_d = 1'b1;
    end

    tx_ready_d = ~hold_full_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b1;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx over five parameter sets
// (8N1, even parity, odd parity, 2 stop bits, CLKS_PER_BIT=2 with odd parity
// and 2 stops). Drivers push {byte, expected start cycle} per accepted byte;
// a per-cycle monitor pops frames and checks line, busy, done and ready.
module tb_uart_tx;

  localparam int NI = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NI-1:0]   tx_valid;
  logic [NI-1:0]   tx_ready;
  logic [NI-1:0]   serial_out;
  logic [NI-1:0]   tx_busy;
  logic [NI-1:0]   tx_done;
  logic [7:0]      tx_byte [NI];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    uart_tx #(
      .CLKS_PER_BIT((g == 4) ? 2 : 4),
      .PARITY_EN   ((g == 1 || g == 2 || g == 4) ? 1'b1 : 1'b0),
      .PARITY_ODD  ((g == 2 || g == 4) ? 1'b1 : 1'b0),
      .STOP_BITS   ((g >= 3) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_byte   (tx_byte[g]),
      .tx_valid  (tx_valid[g]),
      .tx_ready  (tx_ready[g]),
      .serial_out(serial_out[g]),
      .tx_busy   (tx_busy[g]),
      .tx_done   (tx_done[g])
    );
  end

  // Reference configuration per instance.
  function automatic int cpb(input int g);  return (g == 4) ? 2 : 4; endfunction
  function automatic int pe(input int g);   return (g == 1 || g == 2 || g == 4) ? 1 : 0; endfunction
  function automatic int podd(input int g); return (g == 2 || g == 4) ? 1 : 0; endfunction
  function automatic int sb(input int g);   return (g >= 3) ? 2 : 1; endfunction
  function automatic int flen(input int g); return (9 + pe(g) + sb(g)) * cpb(g); endfunction

  // Line value for bit slot idx of a frame carrying b.
  function automatic logic exp_bit(input int g, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (pe(g) != 0 && idx == 9) return (^b) ^ (podd(g) != 0);
    return 1'b1;
  endfunction

  typedef struct {
    logic [7:0] b;
    int         s;
  } exp_t;

  exp_t       q [NI][$];
  int         last_s  [NI];
  int         hold_lo [NI];
  int         hold_hi [NI];
  int         cur_s   [NI];
  logic       act     [NI];
  logic [7:0] cur_b   [NI];

  task automatic model_clear();
    for (int g = 0; g < NI; g++) begin
      q[g].delete();
      last_s[g]  = -100000;
      hold_lo[g] = 1;
      hold_hi[g] = 0;
      act[g]     = 1'b0;
      cur_s[g]   = 0;
      cur_b[g]   = '0;
    end
  endtask

  task automatic check(input string name, input int g, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %b, expected %b", name, g, cyc, got, want);
    end
  endtask

  // Called at a negedge when byte b is presented with tx_ready high,
  // so acceptance happens at the next edge.
  task automatic push_accept(input int g, input logic [7:0] b);
    int   n;
    int   s;
    exp_t e;
    n = cyc + 1;
    s = (n + 2 > last_s[g] + flen(g)) ? n + 2 : last_s[g] + flen(g);
    last_s[g]  = s;
    hold_lo[g] = n;
    hold_hi[g] = s - 2;
    e.b = b;
    e.s = s;
    q[g].push_back(e);
  endtask

  // Per-cycle monitor for one instance.
  task automatic mon_cycle(input int g);
    int   k;
    logic el;
    logic eb;
    logic ed;
    if (!act[g] && q[g].size() > 0 && q[g][0].s == cyc) begin
      cur_b[g] = q[g][0].b;
      cur_s[g] = q[g][0].s;
      q[g].delete(0);
      act[g] = 1'b1;
    end
    el = 1'b1;
    eb = 1'b0;
    ed = 1'b0;
    if (act[g]) begin
      k  = cyc - cur_s[g];
      el = exp_bit(g, cur_b[g], k / cpb(g));
      eb = 1'b1;
      ed = (k == flen(g) - 1);
      if (ed) act[g] = 1'b0;
    end
    check("serial_out", g, serial_out[g], el);
    check("tx_busy", g, tx_busy[g], eb);
    check("tx_done", g, tx_done[g], ed);
    check("tx_ready", g, tx_ready[g], !(cyc >= hold_lo[g] && cyc <= hold_hi[g]));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < NI; g++) mon_cycle(g);
    end
  end

  // Offer byte b so it is accepted no earlier than edge min_edge.
  task automatic send(input int g, input logic [7:0] b, input int min_edge);
    int t;
    t = 0;
    @(negedge clk);
    while ((cyc < min_edge - 1 || !tx_ready[g]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", g, tx_ready[g], 1'b1);
    if (tx_ready[g]) begin
      tx_valid[g] = 1'b1;
      tx_byte[g]  = b;
      push_accept(g, b);
      @(negedge clk);
      tx_valid[g] = 1'b0;
    end
  endtask

  // Valid mostly high with data changing every cycle, ignoring tx_ready.
  task automatic rand_stream(input int g, input int n);
    logic       v;
    logic [7:0] b;
    repeat (n) begin
      @(negedge clk);
      v = ($urandom_range(3) != 0);
      b = 8'($urandom);
      tx_valid[g] = v;
      tx_byte[g]  = b;
      if (v && tx_ready[g]) push_accept(g, b);
    end
    @(negedge clk);
    tx_valid[g] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    bit pend;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      pend = 1'b0;
      for (int g = 0; g < NI; g++) if (q[g].size() != 0 || act[g]) pend = 1'b1;
    end while (pend && t < 3000);
    checks++;
    if (pend) begin
      errors++;
      $display("FAIL drain: frames still outstanding after %0d cycles, expected none", t);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tx_valid = '0;
    for (int g = 0; g < NI; g++) tx_byte[g] = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset in the middle of an all-zero frame.
    for (int g = 0; g < NI; g++) send(g, 8'h00, 0);
    repeat (12) @(negedge clk);
    check("pre_reset_line", 0, serial_out[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      check("rst_serial_out", g, serial_out[g], 1'b1);
      check("rst_tx_ready", g, tx_ready[g], 1'b1);
      check("rst_tx_busy", g, tx_busy[g], 1'b0);
      check("rst_tx_done", g, tx_done[g], 1'b0);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single byte, then back-to-back frames.
    send(0, 8'hA5, 0);
    wait_idle();
    send(0, 8'h00, 0);
    send(0, 8'hFF, 0);
    wait_idle();

    // Parity and stop-bit variants.
    send(1, 8'h07, 0);
    send(2, 8'h07, 0);
    send(3, 8'h3C, 0);
    send(4, 8'h3C, 0);
    wait_idle();

    // Acceptance on the final stop edge with an empty hold register.
    send(0, 8'h5A, 0);
    send(0, 8'hC3, last_s[0] + flen(0) - 1);
    send(3, 8'h81, 0);
    send(3, 8'h7E, last_s[3] + flen(3) - 1);
    wait_idle();

    // Randomized backpressure on every instance concurrently.
    for (int g = 0; g < NI; g++) begin
      automatic int gg = g;
      fork
        rand_stream(gg, 600);
      join_none
    end
    wait fork;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
